// File: rtl/gpr_shadow_dumper_pkg.sv
// Shared types and constants for the GPR shadow dumper.
//
// Purpose : common declarations used by the shadow register file, the scan wrapper and the
//           existing GPR update reporter.
// Contents: default geometry, index width, scan FSM state type, writeback-port record.
package gpr_shadow_dumper_pkg;

  localparam int unsigned GPR_NUM_DEFAULT    = 32;
  localparam int unsigned DATA_WIDTH_DEFAULT = 32;
  localparam int unsigned GPR_IDX_W          = $clog2(GPR_NUM_DEFAULT);

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } scan_state_e;

  // One writeback port as reported by the core for GPR updates.
  typedef struct packed {
    logic [GPR_IDX_W-1:0]          id;
    logic                          wen;
    logic [DATA_WIDTH_DEFAULT-1:0] wdata;
  } wb_port_t;

endpackage

// File: rtl/gpr_shadow_regfile.sv
// Shadow copy of the architectural GPR file.
//
// Purpose : two write ports (port 2 is younger and wins on an index collision), one
//           asynchronous read port. Index 0 is hardwired to zero; writes to it are dropped.
// Ports   : clk, rst (synchronous, active-low)
//           id1/wen1/wdata1  writeback port 1
//           id2/wen2/wdata2  writeback port 2
//           raddr/rdata      combinational read port (no write bypass)
module gpr_shadow_regfile
  import gpr_shadow_dumper_pkg::*;
#(
  parameter int unsigned GPR_NUM    = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(GPR_NUM)-1:0] id1,
  input  logic                       wen1,
  input  logic [DATA_WIDTH-1:0]      wdata1,
  input  logic [$clog2(GPR_NUM)-1:0] id2,
  input  logic                       wen2,
  input  logic [DATA_WIDTH-1:0]      wdata2,
  input  logic [$clog2(GPR_NUM)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]      rdata
);

  logic [DATA_WIDTH-1:0] mem_q [GPR_NUM];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < GPR_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wen1 && (id1 != '0)) begin
        mem_q[id1] <= wdata1;
      end
      // Later assignment takes effect, so port 2 overrides port 1 on the same index.
      if (wen2 && (id2 != '0)) begin
        mem_q[id2] <= wdata2;
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/gpr_shadow_dumper.sv
// Simulation-side GPR shadow with a streaming full-state dump.
//
// Purpose : tracks GPR writebacks into a shadow file and, on request, streams every register
//           (index 0 .. GPR_NUM-1), one per beat, over a valid/ready interface.
// Ports   : clk, rst (synchronous, active-low)
//           id1/wen1/wdata1, id2/wen2/wdata2  writeback ports (port 2 younger)
//           dump_valid/dump_ready             dump request handshake
//           out_valid/out_ready               beat handshake
//           out_id/out_data/out_last          beat payload; out_last on the final index
//           busy                              scan in progress
module gpr_shadow_dumper
  import gpr_shadow_dumper_pkg::*;
#(
  parameter int unsigned GPR_NUM    = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(GPR_NUM)-1:0] id1,
  input  logic                       wen1,
  input  logic [DATA_WIDTH-1:0]      wdata1,
  input  logic [$clog2(GPR_NUM)-1:0] id2,
  input  logic                       wen2,
  input  logic [DATA_WIDTH-1:0]      wdata2,
  input  logic                       dump_valid,
  output logic                       dump_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(GPR_NUM)-1:0] out_id,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned         IdxW    = $clog2(GPR_NUM);
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(GPR_NUM - 1);

  scan_state_e           state_q;
  logic [IdxW-1:0]       idx_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic                  busy_q;
  logic                  dump_ready_q;
  logic [DATA_WIDTH-1:0] rd_data;

  gpr_shadow_regfile #(
    .GPR_NUM    (GPR_NUM),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .id1    (id1),
    .wen1   (wen1),
    .wdata1 (wdata1),
    .id2    (id2),
    .wen2   (wen2),
    .wdata2 (wdata2),
    .raddr  (idx_q),
    .rdata  (rd_data)
  );

  // Scan FSM. All handshake outputs are registered; the index never wraps because the scan
  // leaves on the last beat.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      dump_ready_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          dump_ready_q <= 1'b1;
          if (dump_valid && dump_ready_q) begin
            state_q      <= StScan;
            idx_q        <= '0;
            out_valid_q  <= 1'b1;
            out_last_q   <= (LastIdx == '0);
            busy_q       <= 1'b1;
            dump_ready_q <= 1'b0;
          end
        end
        StScan: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q      <= StIdle;
              idx_q        <= '0;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              busy_q       <= 1'b0;
              dump_ready_q <= 1'b1;
            end else begin
              idx_q      <= idx_q + IdxW'(1);
              out_last_q <= ((idx_q + IdxW'(1)) == LastIdx);
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dump_ready = dump_ready_q;
  assign out_valid  = out_valid_q;
  assign out_id     = idx_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  // Live read: a write to the pending register during a stall shows up the next cycle.
  assign out_data   = out_valid_q ? rd_data : '0;

endmodule

// File: tb/tb_gpr_shadow_dumper.sv
// Scoreboard bench for gpr_shadow_dumper: stimulus pushes expected beats, a monitor pops and
// compares them on every beat handshake.
module tb_gpr_shadow_dumper;

  localparam int N  = 32;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [IW-1:0] id1, id2;
  logic          wen1, wen2;
  logic [31:0]   wdata1, wdata2;
  logic          dump_valid, dump_ready;
  logic          out_valid, out_ready, out_last, busy;
  logic [IW-1:0] out_id;
  logic [31:0]   out_data;

  gpr_shadow_dumper #(
    .GPR_NUM    (N),
    .DATA_WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .id1        (id1),
    .wen1       (wen1),
    .wdata1     (wdata1),
    .id2        (id2),
    .wen2       (wen2),
    .wdata2     (wdata2),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_id     (out_id),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] id;
    logic [31:0]   data;
    logic          last;
  } beat_t;

  beat_t       sb[$];
  beat_t       mon_e;
  logic [31:0] m [N];
  int          passed = 0;
  int          total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_beat: got id %0d, required no beat", out_id);
      end else begin
        mon_e = sb.pop_front();
        check("beat_id", 64'(out_id), 64'(mon_e.id));
        check("beat_data", 64'(out_data), 64'(mon_e.data));
        check("beat_last", 64'(out_last), 64'(mon_e.last));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_dump(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{id: IW'(i), data: m[i], last: (i == N - 1)});
    end
  endtask

  task automatic wb(input logic [IW-1:0] a1, input logic e1, input logic [31:0] d1,
                    input logic [IW-1:0] a2, input logic e2, input logic [31:0] d2);
    id1 = a1; wen1 = e1; wdata1 = d1;
    id2 = a2; wen2 = e2; wdata2 = d2;
    @(posedge clk); #1;
    wen1 = 1'b0; wen2 = 1'b0;
  endtask

  // Runs one dump. Negative *_at arguments disable the corresponding event.
  task automatic run_dump(input int stall_at, input int stall_n, input logic [31:0] stall_old,
                          input logic [31:0] stall_new, input int wr_at,
                          input logic [IW-1:0] wr_id, input logic [31:0] wr_data,
                          input int req_at, input int abort_at, input int exp_cycles);
    int t = 0;
    int cycles = 0;
    int stall_cnt = 0;
    bit wr_done = 1'b0;
    while (!dump_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    if (!dump_ready) begin
      total++;
      $display("FAIL dump_ready_timeout: got dump_ready 0, required 1 within 100 cycles");
      return;
    end
    dump_valid = 1'b1;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    dump_valid = 1'b0;
    while (busy && cycles < 200) begin
      if (abort_at >= 0 && out_id == IW'(abort_at)) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < N; i++) m[i] = '0;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready_in_reset", 64'(dump_ready), 64'd0);
        @(posedge clk); #1;
        check("abort_ready_after", 64'(dump_ready), 64'd1);
        return;
      end
      wen1 = 1'b0;
      if (wr_at >= 0 && !wr_done && out_id == IW'(wr_at)) begin
        wen1 = 1'b1; id1 = wr_id; wdata1 = wr_data; wr_done = 1'b1;
      end
      if (req_at >= 0 && out_id == IW'(req_at)) begin
        dump_valid = 1'b1;
        check("ready_low_while_busy", 64'(dump_ready), 64'd0);
      end
      if (stall_at >= 0 && out_id == IW'(stall_at) && stall_cnt < stall_n) begin
        out_ready = 1'b0;
        if (stall_cnt == 0) check("stall_data_old", 64'(out_data), 64'(stall_old));
        if (stall_cnt == 1) check("stall_data_new", 64'(out_data), 64'(stall_new));
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      @(posedge clk); #1;
      cycles++;
    end
    wen1      = 1'b0;
    out_ready = 1'b1;
    check("dump_cycles", 64'(cycles), 64'(exp_cycles));
    check("ready_after_dump", 64'(dump_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b0; id1 = '0; id2 = '0; wen1 = 1'b0; wen2 = 1'b0;
    wdata1 = '0; wdata2 = '0; dump_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < N; i++) m[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_id", 64'(out_id), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dump_ready", 64'(dump_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("dump_ready_after_rst", 64'(dump_ready), 64'd1);

    // Basic dump with one write per port.
    wb(5'd5, 1'b1, 32'h1234, 5'd7, 1'b1, 32'hBEEF);
    m[5] = 32'h1234; m[7] = 32'hBEEF;
    push_dump(N);
    run_dump(-1, 0, 0, 0, -1, 0, 0, -1, -1, 32);

    // Same-index collision (port 2 wins) and dropped writes to r0.
    wb(5'd3, 1'b1, 32'hAAAA, 5'd3, 1'b1, 32'h5555);
    m[3] = 32'h5555;
    wb(5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF);
    push_dump(N);
    run_dump(-1, 0, 0, 0, -1, 0, 0, -1, -1, 32);

    // Backpressure at id 4 for 3 cycles with a live write of r4.
    m[4] = 32'h77;
    push_dump(N);
    run_dump(4, 3, 32'h0, 32'h77, 4, 5'd4, 32'h77, -1, -1, 35);

    // Write to an emitted register mid-scan; a dump request mid-scan is held off.
    push_dump(N);
    run_dump(-1, 0, 0, 0, 10, 5'd2, 32'h99, 15, -1, 32);
    m[2] = 32'h99;
    push_dump(N);
    run_dump(-1, 0, 0, 0, -1, 0, 0, -1, -1, 32);

    // Reset in the middle of a scan, then a clean dump of an all-zero shadow.
    push_dump(13);
    run_dump(-1, 0, 0, 0, -1, 0, 0, -1, 12, 0);
    push_dump(N);
    run_dump(-1, 0, 0, 0, -1, 0, 0, -1, -1, 32);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpr_shadow_dumper.md
Name: gpr_shadow_dumper

Overview:
- Simulation-side shadow of the architectural GPR file, fed by the same dual writeback ports the core drives for difftest GPR updates.
- On request, a scan FSM reads the shadow back and streams every register, one per beat, over a valid/ready interface.
- The stream feeds checkpoint/compare logic: a full-state dump at trap, halt, or periodic sync.
- Pure RTL, no DPI-C inside; the consumer decides what to do with each beat.

Parameters:
- GPR_NUM, 32, number of architectural GPRs; power of two, 2..256.
- DATA_WIDTH, 32, GPR width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (rst==0 resets).
- id1  in  $clog2(GPR_NUM)  writeback port 1 register index.
- wen1  in  1  writeback port 1 enable.
- wdata1  in  DATA_WIDTH  writeback port 1 data.
- id2  in  $clog2(GPR_NUM)  writeback port 2 register index (younger in program order).
- wen2  in  1  writeback port 2 enable.
- wdata2  in  DATA_WIDTH  writeback port 2 data.
- dump_valid  in  1  dump request.
- dump_ready  out  1  request accepted when dump_valid && dump_ready.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_id  out  $clog2(GPR_NUM)  register index of beat.
- out_data  out  DATA_WIDTH  register value of beat.
- out_last  out  1  marks the final beat (out_id==GPR_NUM-1).
- busy  out  1  scan in progress.

Behaviour:
- Reset (rst==0 at a clk edge):
  - All shadow entries become 0; state becomes IDLE; scan index becomes 0.
  - Outputs: out_valid=0, out_id=0, out_data=0, out_last=0, busy=0, dump_ready=0 during reset and 1 from the first cycle after reset is released.
  - Reset mid-scan aborts the scan; no further beats are emitted.
- Shadow update (every non-reset cycle, in every state):
  - A port whose enable is set and whose index is non-zero writes its data.
  - Writes to index 0 are dropped; entry 0 always reads 0.
  - wen1 && wen2 with id1==id2: port 2 wins.
  - Writes become visible on the cycle after the edge; there is no same-cycle bypass.
- FSM states: IDLE, SCAN.
  - IDLE: dump_ready=1, out_valid=0, busy=0. A handshake on dump_valid moves to SCAN with index=0.
  - SCAN: dump_ready=0, busy=1, out_valid=1, out_id=index, out_data=shadow[index], out_last=(index==GPR_NUM-1).
    - On out_valid && out_ready with !out_last: index+1.
    - On out_valid && out_ready with out_last: return to IDLE.
    - Without out_ready: index holds.
- Latency: first beat is presented the cycle after dump acceptance. Minimum dump length is GPR_NUM cycles with out_ready held high.
- Stall semantics: while stalled, out_id is stable. out_data is "live": a write to the pending register during a stall changes out_data on the following cycle. Consumers sample only at handshake.
- Entries already emitted are not revisited. A write to an emitted register during a scan is reflected only in the next dump.
- dump_valid while busy is ignored (not queued). The requester must hold it until dump_ready.
- Back-to-back dumps: dump_ready rises the cycle after the last handshake.
- out_id width arithmetic: index is $clog2(GPR_NUM) bits. The last beat is detected by comparison, not by wrap. The index never wraps because the FSM leaves SCAN on out_last.

Decomposition:
- Shared package:
  - localparam GPR_IDX_W = $clog2(GPR_NUM).
  - FSM state enum {IDLE, SCAN}.
  - Writeback-port struct {id, wen, wdata}, reused by the existing GPR update reporter.
- One natural sub-module: gpr_shadow_regfile. It holds 2 write ports with port-2 priority, ignores index 0, and provides 1 asynchronous read port. The FSM wrapper holds the scan index and handshake.

Test Plan:
- Reset, then write r5=0x1234 (port 1) and r7=0xBEEF (port 2) in one cycle, then dump with out_ready=1 -> 32 beats on consecutive cycles. Beat 5 carries 0x1234, beat 7 carries 0xBEEF, all other beats 0. out_last only on id 31. dump_ready=1 the next cycle.
- Same-cycle collision: id1=id2=3, wdata1=0xAAAA, wdata2=0x5555 -> dump shows r3=0x5555.
- Write r0=0xFFFF_FFFF on both ports -> dump beat 0 data=0.
- Backpressure: dump; hold out_ready=0 at id 4 for 3 cycles; write r4=0x77 during the stall -> out_id stays 4, out_data becomes 0x77 the next cycle, and a handshake then advances to id 5. Total 35 cycles.
- Write r2=0x99 while out_id=10 -> this dump shows the old r2. A second dump shows 0x99. dump_valid asserted mid-scan is not accepted until IDLE.
- Assert rst=0 for one cycle at out_id=12 -> out_valid=0 and busy=0 the next cycle. A subsequent dump shows all zeros, starting at id 0.
